// File: rtl/receptor_morse.sv
// Morse receiver: synchronizes the keyed line, times marks and gaps,
// and emits one ASCII code per character plus a space per word gap.
`timescale 1ns/1ps
module receptor_morse #(
  parameter int UNIT_CYCLES = 12500000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       tono,
  output logic [6:0] caracter,
  output logic       valido,
  output logic       ocupado
);

  localparam int CW = $clog2(8 * UNIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(8 * UNIT_CYCLES);
  localparam logic [CW-1:0] DASH_MIN = CW'(2 * UNIT_CYCLES);
  localparam logic [CW-1:0] CHAR_GAP = CW'(3 * UNIT_CYCLES);
  localparam logic [CW-1:0] WORD_GAP = CW'(7 * UNIT_CYCLES);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, WAIT_WORD} state_e;

  state_e        state_q, state_d;
  logic          s1_q, ts_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]    pat_q, pat_d;
  logic [2:0]    nsym_q, nsym_d;
  logic          ovf_q, ovf_d;
  logic [6:0]    char_q, char_d;
  logic          val_q, val_d;
  logic [6:0]    code;
  logic          sym;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q    <= 1'b0;
      ts_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      nsym_q  <= '0;
      ovf_q   <= 1'b0;
      char_q  <= 7'h00;
      val_q   <= 1'b0;
    end else begin
      s1_q    <= tono;
      ts_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      nsym_q  <= nsym_d;
      ovf_q   <= ovf_d;
      char_q  <= char_d;
      val_q   <= val_d;
    end
  end

  // Newest symbol sits in bit 0, so patterns read left to right.
  always_comb begin
    code = 7'h3F;
    if (!ovf_q) begin
      case ({nsym_q, pat_q})
        {3'd1, 5'b00000}: code = 7'h45;
        {3'd1, 5'b00001}: code = 7'h54;
        {3'd2, 5'b00000}: code = 7'h49;
        {3'd2, 5'b00001}: code = 7'h41;
        {3'd2, 5'b00010}: code = 7'h4E;
        {3'd2, 5'b00011}: code = 7'h4D;
        {3'd3, 5'b00000}: code = 7'h53;
        {3'd3, 5'b00001}: code = 7'h55;
        {3'd3, 5'b00010}: code = 7'h52;
        {3'd3, 5'b00011}: code = 7'h57;
        {3'd3, 5'b00100}: code = 7'h44;
        {3'd3, 5'b00101}: code = 7'h4B;
        {3'd3, 5'b00110}: code = 7'h47;
        {3'd3, 5'b00111}: code = 7'h4F;
        {3'd4, 5'b00000}: code = 7'h48;
        {3'd4, 5'b00001}: code = 7'h56;
        {3'd4, 5'b00010}: code = 7'h46;
        {3'd4, 5'b00100}: code = 7'h4C;
        {3'd4, 5'b00110}: code = 7'h50;
        {3'd4, 5'b00111}: code = 7'h4A;
        {3'd4, 5'b01000}: code = 7'h42;
        {3'd4, 5'b01001}: code = 7'h58;
        {3'd4, 5'b01010}: code = 7'h43;
        {3'd4, 5'b01011}: code = 7'h59;
        {3'd4, 5'b01100}: code = 7'h5A;
        {3'd4, 5'b01101}: code = 7'h51;
        {3'd5, 5'b00000}: code = 7'h35;
        {3'd5, 5'b00001}: code = 7'h34;
        {3'd5, 5'b00011}: code = 7'h33;
        {3'd5, 5'b00111}: code = 7'h32;
        {3'd5, 5'b01111}: code = 7'h31;
        {3'd5, 5'b10000}: code = 7'h36;
        {3'd5, 5'b11000}: code = 7'h37;
        {3'd5, 5'b11100}: code = 7'h38;
        {3'd5, 5'b11110}: code = 7'h39;
        {3'd5, 5'b11111}: code = 7'h30;
        default:          code = 7'h3F;
      endcase
    end
  end

  assign cnt_inc = cnt_q + CW'(1);
  assign sym     = (cnt_q >= DASH_MIN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    nsym_d  = nsym_q;
    ovf_d   = ovf_q;
    char_d  = char_q;
    val_d   = 1'b0;
    unique case (state_q)
      IDLE, WAIT_WORD: begin
        if (ts_q) begin
          state_d = MARK;
          cnt_d   = CW'(1);
          pat_d   = '0;
          nsym_d  = '0;
          ovf_d   = 1'b0;
        end else if (state_q == WAIT_WORD) begin
          cnt_d = cnt_inc;
          if (cnt_inc == WORD_GAP) begin
            char_d  = 7'h20;
            val_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      MARK: begin
        if (ts_q) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_inc;
        end else begin
          state_d = SPACE;
          cnt_d   = CW'(1);
          if (nsym_q == 3'd5) begin
            ovf_d = 1'b1;
          end else begin
            pat_d  = {pat_q[3:0], sym};
            nsym_d = nsym_q + 3'd1;
          end
        end
      end
      SPACE: begin
        if (ts_q) begin
          state_d = MARK;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CHAR_GAP) begin
            char_d  = code;
            val_d   = 1'b1;
            state_d = WAIT_WORD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign caracter = char_q;
  assign valido   = val_q;
  assign ocupado  = (state_q != IDLE);

endmodule

// File: tb/tb_receptor_morse.sv
// Directed bench for receptor_morse with UNIT_CYCLES=4.
`timescale 1ns/1ps
module tb_receptor_morse;

  logic       clk = 1'b0;
  logic       rst;
  logic       tono;
  logic [6:0] caracter;
  logic       valido;
  logic       ocupado;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int dbl = 0;
  logic prev_v = 1'b0;
  int fall;
  logic [6:0] ev_ch[$];
  int ev_cyc[$];

  receptor_morse #(.UNIT_CYCLES(4)) dut (
    .CLK(clk),
    .RST(rst),
    .tono(tono),
    .caracter(caracter),
    .valido(valido),
    .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // valido pulses are logged with the posedge count that produced them.
  always @(negedge clk) begin
    if (valido) begin
      ev_ch.push_back(caracter);
      ev_cyc.push_back(cyc);
      if (prev_v) dbl++;
    end
    prev_v = valido;
  end

  task automatic hold(input logic v, input int n);
    tono = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    ev_ch.delete();
    ev_cyc.delete();
  endtask

  function automatic int evc(input int i);
    return (i < ev_ch.size()) ? int'(ev_ch[i]) : -1;
  endfunction

  initial begin
    rst = 1'b1;
    tono = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_caracter", int'(caracter), 'h00);
    chk("rst_valido", int'(valido), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    rst = 1'b0;
    hold(1'b0, 4);

    // E then word space, exact timing
    clr();
    hold(1'b1, 4);
    fall = cyc;
    hold(1'b0, 40);
    chk("e_count", ev_ch.size(), 2);
    chk("e_char", evc(0), 'h45);
    chk("e_cyc", (ev_cyc.size() > 0) ? ev_cyc[0] - fall : -1, 14);
    chk("sp_char", evc(1), 'h20);
    chk("sp_cyc", (ev_cyc.size() > 1) ? ev_cyc[1] - fall : -1, 30);
    chk("idle_ocupado", int'(ocupado), 0);
    chk("hold_caracter", int'(caracter), 'h20);

    // dot/dash threshold
    clr();
    hold(1'b1, 7);
    hold(1'b0, 40);
    chk("mark7", evc(0), 'h45);
    clr();
    hold(1'b1, 8);
    hold(1'b0, 40);
    chk("mark8", evc(0), 'h54);
    clr();
    hold(1'b1, 40);
    hold(1'b0, 40);
    chk("mark40", evc(0), 'h54);

    // gap threshold: 11 keeps the character, 12 splits it
    clr();
    hold(1'b1, 4); hold(1'b0, 11);
    hold(1'b1, 4); hold(1'b0, 11);
    hold(1'b1, 4); hold(1'b0, 40);
    chk("gap11_count", ev_ch.size(), 2);
    chk("gap11_char", evc(0), 'h53);
    clr();
    hold(1'b1, 4); hold(1'b0, 12);
    hold(1'b1, 4); hold(1'b0, 12);
    hold(1'b1, 4); hold(1'b0, 40);
    chk("gap12_count", ev_ch.size(), 4);
    chk("gap12_c0", evc(0), 'h45);
    chk("gap12_c1", evc(1), 'h45);
    chk("gap12_c2", evc(2), 'h45);

    // SOS
    clr();
    dbl = 0;
    hold(1'b1, 4); hold(1'b0, 4);
    hold(1'b1, 4); hold(1'b0, 4);
    hold(1'b1, 4); hold(1'b0, 12);
    hold(1'b1, 12); hold(1'b0, 4);
    hold(1'b1, 12); hold(1'b0, 4);
    hold(1'b1, 12); hold(1'b0, 12);
    hold(1'b1, 4); hold(1'b0, 4);
    hold(1'b1, 4); hold(1'b0, 4);
    hold(1'b1, 4); hold(1'b0, 40);
    chk("sos_count", ev_ch.size(), 4);
    chk("sos_c0", evc(0), 'h53);
    chk("sos_c1", evc(1), 'h4F);
    chk("sos_c2", evc(2), 'h53);
    chk("sos_c3", evc(3), 'h20);
    chk("sos_single_pulse", dbl, 0);

    // overflow and the longest legal pattern
    clr();
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 4); hold(1'b0, 4);
    end
    hold(1'b1, 4); hold(1'b0, 40);
    chk("ovf_char", evc(0), 'h3F);
    clr();
    for (int i = 0; i < 4; i++) begin
      hold(1'b1, 12); hold(1'b0, 4);
    end
    hold(1'b1, 12); hold(1'b0, 40);
    chk("zero_char", evc(0), 'h30);

    // reset during the second dot of S
    clr();
    hold(1'b1, 4); hold(1'b0, 4);
    hold(1'b1, 2);
    rst = 1'b1;
    hold(1'b0, 2);
    chk("mid_rst_caracter", int'(caracter), 'h00);
    chk("mid_rst_ocupado", int'(ocupado), 0);
    rst = 1'b0;
    hold(1'b0, 40);
    chk("mid_rst_no_valido", ev_ch.size(), 0);
    chk("mid_rst_caracter_held", int'(caracter), 'h00);
    hold(1'b1, 4);
    hold(1'b0, 40);
    chk("post_rst_char", evc(0), 'h45);
    chk("post_rst_count", ev_ch.size(), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/receptor_morse.md
RECEPTOR_MORSE -- requirements
Module: receptor_morse

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 12500000, meaning clock cycles per Morse time unit; legal range >= 2.
REQ-002 SHALL have port CLK  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port tono  input  1  asynchronous keyed Morse line; 1 = mark (tone on), 0 = space.
REQ-005 SHALL have port caracter  output  7  decoded 7-bit ASCII code of the last emitted character.
REQ-006 SHALL have port valido  output  1  one-cycle strobe marking a new value on caracter.
REQ-007 SHALL have port ocupado  output  1  high while the FSM is in any state other than IDLE.

Function
REQ-008 SHALL pass tono through a 2-flop synchronizer; all timing below refers to the synchronizer output ts, which lags tono by 2 cycles.
REQ-009 SHALL implement FSM states IDLE, MARK, SPACE and WAIT_WORD.
REQ-010 SHALL, in IDLE, move to MARK on ts=1 and clear the symbol buffer, symbol count and overflow flag.
REQ-011 SHALL, in MARK, count consecutive ts=1 cycles in a counter saturating at 8*UNIT_CYCLES.
REQ-012 SHALL, on the ts 1->0 transition, classify the mark as a dot if its length is < 2*UNIT_CYCLES and as a dash otherwise, append the symbol to the buffer, and go to SPACE.
REQ-013 SHALL buffer up to 5 symbols in order; a 6th or later symbol SHALL set the overflow flag and SHALL not be stored.
REQ-014 SHALL, in SPACE, count consecutive ts=0 cycles; ts=1 before the count reaches 3*UNIT_CYCLES SHALL return to MARK and continue the same character.
REQ-015 SHALL, in the cycle ts=0 has been seen for 3*UNIT_CYCLES consecutive cycles, register the decoded code into caracter, pulse valido for exactly one cycle, and enter WAIT_WORD.
REQ-016 SHALL decode the buffer per the ITU table for A-Z and 0-9 to uppercase ASCII (7'h41-7'h5A, 7'h30-7'h39).
REQ-017 SHALL output 7'h3F ('?') for an overflowed buffer or any pattern not in the table.
REQ-018 SHALL, in WAIT_WORD, keep counting the same gap; ts=1 before 7*UNIT_CYCLES SHALL go to MARK with no space emitted.
REQ-019 SHALL, when the gap reaches 7*UNIT_CYCLES, emit caracter=7'h20 with a one-cycle valido pulse and go to IDLE; IDLE SHALL never emit, so at most one space follows each word.
REQ-020 SHALL hold caracter stable between valido pulses.
REQ-021 SHALL keep valido low in every cycle not named in REQ-015 and REQ-019.

Reset
REQ-022 SHALL, while RST=1 at a rising edge, set caracter=7'h00, valido=0, ocupado=0, state=IDLE, and clear the synchronizer flops, counters, symbol buffer and overflow flag.
REQ-023 SHALL discard any partially received character when RST is asserted mid-MARK or mid-SPACE, with no valido pulse.
REQ-024 SHALL, if tono=1 at reset release, measure the mark from the first cycle ts=1.

Verification (UNIT_CYCLES=4; lengths in ts cycles)
REQ-025 SHALL check: mark 4, then low -> valido with caracter=7'h45 ('E') at the 12th low cycle -> valido with caracter=7'h20 at the 28th low cycle -> no further valido.
REQ-026 SHALL check the dot/dash threshold: mark 7 -> 7'h45 ('E'); mark 8 -> 7'h54 ('T'); mark 40 (saturating) -> 7'h54.
REQ-027 SHALL check the gap threshold: three marks of 4 separated by 11-cycle gaps -> single 7'h53 ('S'); the same marks separated by 12-cycle gaps -> three 7'h45 pulses.
REQ-028 SHALL check "SOS": marks 4,4,4 (gap 4), gap 12, marks 12,12,12 (gap 4), gap 12, marks 4,4,4, then low -> 7'h53, 7'h4F, 7'h53, 7'h20 in order, each valido exactly one cycle.
REQ-029 SHALL check overflow: six dots with 4-cycle gaps, then low -> caracter=7'h3F; five dashes -> 7'h30 ('0').
REQ-030 SHALL check reset mid-operation: RST pulsed during the second dot of 'S' -> no valido, caracter=7'h00, ocupado=0; the next full 'E' decodes normally.
